// File: rtl/mul_rr_arbiter_if.sv
// Operand/result handshake bundle for mul_rr_arbiter: two requester channels plus one result channel.
interface mul_rr_arbiter_if #(
  parameter int unsigned n = 8
);
  logic [n-1:0]   a0;
  logic [n-1:0]   b0;
  logic           sign0;
  logic           vld0;
  logic           rdy0;
  logic [n-1:0]   a1;
  logic [n-1:0]   b1;
  logic           sign1;
  logic           vld1;
  logic           rdy1;
  logic [2*n-1:0] res;
  logic           res_id;
  logic           res_vld;
  logic           res_rdy;

  modport master (
    output a0, b0, sign0, vld0, a1, b1, sign1, vld1, res_rdy,
    input  rdy0, rdy1, res, res_id, res_vld
  );

  modport slave (
    input  a0, b0, sign0, vld0, a1, b1, sign1, vld1, res_rdy,
    output rdy0, rdy1, res, res_id, res_vld
  );
endinterface

// File: rtl/mul_rr_arbiter.sv
// Two-requester round-robin front end for a shared 2-stage signed/unsigned multiplier.
// Optional per-requester accept counters cnt0/cnt1 when MUL_RR_ARBITER_STATS_EN is defined.
module mul_rr_arbiter #(
  parameter int unsigned n = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mul_rr_arbiter_if.slave      bus
`ifdef MUL_RR_ARBITER_STATS_EN
  ,
  output logic [15:0]          cnt0,
  output logic [15:0]          cnt1
`endif
);

  localparam int unsigned W = 2 * n;

  logic           w_adv;
  logic           w_gnt0;
  logic           w_gnt1;
  logic           w_gnt_vld;
  logic [W-1:0]   w_a_ext;
  logic [W-1:0]   w_b_ext;
  logic [W-1:0]   w_prod;

  logic           r_ptr;
  logic           r_s1_vld;
  logic [n-1:0]   r_s1_a;
  logic [n-1:0]   r_s1_b;
  logic           r_s1_sign;
  logic           r_s1_id;
  logic           r_s2_vld;
  logic [W-1:0]   r_s2_prod;
  logic           r_s2_id;

  // The whole pipe advances together whenever the output slot can move.
  assign w_adv = !r_s2_vld || bus.res_rdy;

  // Under contention the requester that did not win last time is granted.
  assign w_gnt0    = bus.vld0 && (!bus.vld1 || r_ptr);
  assign w_gnt1    = bus.vld1 && (!bus.vld0 || !r_ptr);
  assign w_gnt_vld = w_gnt0 || w_gnt1;

  assign bus.rdy0 = w_gnt0 && w_adv;
  assign bus.rdy1 = w_gnt1 && w_adv;

  // Low 2n bits of the extended product equal the true signed/unsigned product.
  assign w_a_ext = r_s1_sign ? {{n{r_s1_a[n-1]}}, r_s1_a} : {{n{1'b0}}, r_s1_a};
  assign w_b_ext = r_s1_sign ? {{n{r_s1_b[n-1]}}, r_s1_b} : {{n{1'b0}}, r_s1_b};
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr     <= 1'b1;
      r_s1_vld  <= 1'b0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s1_sign <= 1'b0;
      r_s1_id   <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s2_prod <= '0;
      r_s2_id   <= 1'b0;
    end else if (w_adv) begin
      r_s2_vld  <= r_s1_vld;
      r_s2_prod <= w_prod;
      r_s2_id   <= r_s1_id;
      r_s1_vld  <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_s1_a    <= w_gnt1 ? bus.a1 : bus.a0;
        r_s1_b    <= w_gnt1 ? bus.b1 : bus.b0;
        r_s1_sign <= w_gnt1 ? bus.sign1 : bus.sign0;
        r_s1_id   <= w_gnt1;
        r_ptr     <= w_gnt1;
      end
    end
  end

  assign bus.res     = r_s2_prod;
  assign bus.res_id  = r_s2_id;
  assign bus.res_vld = r_s2_vld;

`ifdef MUL_RR_ARBITER_STATS_EN
  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Accept counters wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (bus.vld0 && bus.rdy0) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (bus.vld1 && bus.rdy1) r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Directed self-checking bench for mul_rr_arbiter with n=4.
module tb_mul_rr_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mul_rr_arbiter_if #(.n(4)) bus ();

`ifdef MUL_RR_ARBITER_STATS_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  mul_rr_arbiter #(.n(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef MUL_RR_ARBITER_STATS_EN
    ,
    .cnt0  (cnt0),
    .cnt1  (cnt1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ref_prod(input logic [3:0] a, input logic [3:0] b, input logic s);
    int p;
    if (s) p = int'($signed(a)) * int'($signed(b));
    else   p = int'(a) * int'(b);
    return 8'(p);
  endfunction

  task automatic clear_inputs();
    bus.a0 = '0; bus.b0 = '0; bus.sign0 = 1'b0; bus.vld0 = 1'b0;
    bus.a1 = '0; bus.b1 = '0; bus.sign1 = 1'b0; bus.vld1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    bus.res_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (bus.res_vld !== 1'b0 || bus.res !== 8'h00 || bus.res_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: vld=%b res=%h id=%b, want 0/00/0", bus.res_vld, bus.res, bus.res_id);
    end
    bus.vld0 = 1'b1; bus.vld1 = 1'b1;
    #1;
    checks++;
    if (bus.rdy0 !== 1'b1 || bus.rdy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_grant: rdy0=%b rdy1=%b, want 1 0", bus.rdy0, bus.rdy1);
    end
    clear_inputs();
  endtask

  task automatic test_single();
    do_reset();
    bus.vld0 = 1'b1; bus.a0 = 4'hF; bus.b0 = 4'hF; bus.sign0 = 1'b0; bus.res_rdy = 1'b1;
    #1;
    checks++;
    if (bus.rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL single_rdy0: got %b want 1", bus.rdy0);
    end
    @(negedge clk);
    bus.vld0 = 1'b0;
    #1;
    checks++;
    if (bus.res_vld !== 1'b0) begin
      errors++;
      $display("FAIL single_latency_early: res_vld=%b want 0", bus.res_vld);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.res_vld !== 1'b1 || bus.res !== 8'hE1 || bus.res_id !== 1'b0) begin
      errors++;
      $display("FAIL single_result: vld=%b res=%h id=%b, want 1/e1/0", bus.res_vld, bus.res, bus.res_id);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.res_vld !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: res_vld=%b want 0", bus.res_vld);
    end
  endtask

  task automatic test_contention();
    logic       exp_id [4];
    logic [7:0] exp_res [4];
    int         nres;
    exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_res = '{8'd6, 8'd10, 8'd6, 8'd10};
    nres = 0;
    do_reset();
    bus.a0 = 4'd3; bus.b0 = 4'd2; bus.a1 = 4'd2; bus.b1 = 4'd5;
    bus.res_rdy = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus.vld0 = (cyc < 4);
      bus.vld1 = (cyc < 4);
      #1;
      if (cyc < 4) begin
        checks++;
        if (bus.rdy0 !== ((cyc % 2) == 0) || bus.rdy1 !== ((cyc % 2) == 1)) begin
          errors++;
          $display("FAIL rr_grant[%0d]: rdy0=%b rdy1=%b, want %b %b",
                   cyc, bus.rdy0, bus.rdy1, (cyc % 2) == 0, (cyc % 2) == 1);
        end
      end
      if (bus.res_vld === 1'b1 && nres < 4) begin
        checks++;
        if (bus.res_id !== exp_id[nres] || bus.res !== exp_res[nres]) begin
          errors++;
          $display("FAIL rr_result[%0d]: id=%b res=%h, want %b %h",
                   nres, bus.res_id, bus.res, exp_id[nres], exp_res[nres]);
        end
        nres++;
      end
    end
    checks++;
    if (nres != 4) begin
      errors++;
      $display("FAIL rr_result_count: got %0d want 4", nres);
    end
    clear_inputs();
  endtask

  task automatic test_sweep();
    logic [7:0] exp_q [$];
    logic       id_q  [$];
    logic [7:0] v0;
    logic [7:0] v1;
    logic [7:0] e;
    logic       eid;
    int k0, k1, got, cyc;
    k0 = 0; k1 = 0; got = 0; cyc = 0;
    do_reset();
    while (got < 256 && cyc < 4000) begin
      @(negedge clk);
      bus.res_rdy = ($urandom_range(0, 3) != 0);
      v0 = 8'(2 * k0);
      v1 = 8'(2 * k1 + 1);
      bus.vld0 = (k0 < 128); bus.a0 = v0[7:4]; bus.b0 = v0[3:0]; bus.sign0 = v0[1] ^ v0[0];
      bus.vld1 = (k1 < 128); bus.a1 = v1[7:4]; bus.b1 = v1[3:0]; bus.sign1 = v1[1] ^ v1[0];
      #1;
      if (bus.res_vld === 1'b1 && bus.res_rdy === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sweep_extra: unexpected res=%h id=%b", bus.res, bus.res_id);
        end else begin
          e = exp_q.pop_front();
          eid = id_q.pop_front();
          if (bus.res !== e || bus.res_id !== eid) begin
            errors++;
            $display("FAIL sweep_result[%0d]: res=%h id=%b, want %h %b", got, bus.res, bus.res_id, e, eid);
          end
        end
        got++;
      end
      if (bus.vld0 === 1'b1 && bus.rdy0 === 1'b1) begin
        exp_q.push_back(ref_prod(bus.a0, bus.b0, bus.sign0));
        id_q.push_back(1'b0);
        k0++;
      end
      if (bus.vld1 === 1'b1 && bus.rdy1 === 1'b1) begin
        exp_q.push_back(ref_prod(bus.a1, bus.b1, bus.sign1));
        id_q.push_back(1'b1);
        k1++;
      end
      cyc++;
    end
    checks++;
    if (got != 256) begin
      errors++;
      $display("FAIL sweep_count: got %0d results want 256 (cycle budget)", got);
    end
    clear_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    bus.res_rdy = 1'b0;
    bus.vld0 = 1'b1; bus.a0 = 4'd2; bus.b0 = 4'd3;
    @(negedge clk);
    bus.vld0 = 1'b0; bus.vld1 = 1'b1; bus.a1 = 4'd4; bus.b1 = 4'd4;
    @(negedge clk);
    bus.vld0 = 1'b1; bus.a0 = 4'd5; bus.b0 = 4'd3; bus.vld1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (bus.rdy0 !== 1'b0 || bus.rdy1 !== 1'b0 || bus.res_vld !== 1'b1 ||
          bus.res !== 8'd6 || bus.res_id !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: rdy=%b%b vld=%b res=%h id=%b, want 00/1/06/0",
                 i, bus.rdy0, bus.rdy1, bus.res_vld, bus.res, bus.res_id);
      end
    end
    @(negedge clk);
    bus.res_rdy = 1'b1; bus.vld1 = 1'b0;
    #1;
    checks++;
    if (bus.rdy0 !== 1'b1 || bus.res !== 8'd6 || bus.res_id !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: rdy0=%b res=%h id=%b, want 1/06/0", bus.rdy0, bus.res, bus.res_id);
    end
    @(negedge clk);
    bus.vld0 = 1'b0;
    #1;
    checks++;
    if (bus.res_vld !== 1'b1 || bus.res !== 8'd16 || bus.res_id !== 1'b1) begin
      errors++;
      $display("FAIL stall_drain1: vld=%b res=%h id=%b, want 1/10/1", bus.res_vld, bus.res, bus.res_id);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.res_vld !== 1'b1 || bus.res !== 8'd15 || bus.res_id !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain2: vld=%b res=%h id=%b, want 1/0f/0", bus.res_vld, bus.res, bus.res_id);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.res_vld !== 1'b0) begin
      errors++;
      $display("FAIL stall_empty: res_vld=%b want 0", bus.res_vld);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.res_rdy = 1'b0;
    bus.vld1 = 1'b1; bus.a1 = 4'd3; bus.b1 = 4'd3;
    @(negedge clk);
    bus.vld1 = 1'b0; bus.vld0 = 1'b1; bus.a0 = 4'd2; bus.b0 = 4'd2;
    @(negedge clk);
    bus.vld0 = 1'b0;
    #1;
    checks++;
    if (bus.res_vld !== 1'b1 || bus.res !== 8'd9) begin
      errors++;
      $display("FAIL midreset_fill: vld=%b res=%h, want 1/09", bus.res_vld, bus.res);
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.res_vld !== 1'b0 || bus.res !== 8'h00) begin
      errors++;
      $display("FAIL midreset_flush: vld=%b res=%h, want 0/00", bus.res_vld, bus.res);
    end
    rst_n = 1'b1;
    bus.vld0 = 1'b1; bus.vld1 = 1'b1; bus.res_rdy = 1'b1;
    #1;
    checks++;
    if (bus.rdy0 !== 1'b1 || bus.rdy1 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_grant0: rdy0=%b rdy1=%b, want 1 0", bus.rdy0, bus.rdy1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.rdy0 !== 1'b0 || bus.rdy1 !== 1'b1) begin
      errors++;
      $display("FAIL midreset_grant1: rdy0=%b rdy1=%b, want 0 1", bus.rdy0, bus.rdy1);
    end
    clear_inputs();
  endtask

`ifdef MUL_RR_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset();
    bus.res_rdy = 1'b1;
    bus.vld0 = 1'b1;
    repeat (5) @(negedge clk);
    bus.vld0 = 1'b0; bus.vld1 = 1'b1;
    repeat (3) @(negedge clk);
    bus.vld1 = 1'b0;
    #1;
    checks++;
    if (cnt0 !== 16'd5 || cnt1 !== 16'd3) begin
      errors++;
      $display("FAIL stats_count: cnt0=%0d cnt1=%0d, want 5 3", cnt0, cnt1);
    end
    do_reset();
    #1;
    checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL stats_reset: cnt0=%0d cnt1=%0d, want 0 0", cnt0, cnt1);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    clear_inputs();
    bus.res_rdy = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_sweep();
    test_stall();
    test_reset_mid();
`ifdef MUL_RR_ARBITER_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
